// File: rtl/accumulator_bank.sv
// accumulator_bank
//   Output accumulator sitting under the systolic array. Holds DEPTH rows of
//   ARR_SIZE signed partial sums, adds incoming column vectors into a chosen
//   row (optionally saturating), and drains the whole tile word by word into
//   the output buffer, zeroing each entry as the buffer accepts it.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous reset, active low
//   in_valid              accumulate accumulated_val into row in_row
//   in_row                target row
//   accumulated_val       ARR_SIZE signed lanes, lane 0 in the LSBs
//   acc_clear             overwrite the row with the incoming lanes instead of adding
//   sat_en                clamp on signed overflow instead of wrapping
//   store_output          start a drain (only honoured while idle)
//   op_buffer_address     base address for the drain, latched at start
//   output_data           drained word, 0 when output_buffer_enable is low
//   output_buffer_addr    write address for output_data
//   output_buffer_enable  word valid
//   output_buffer_ready   buffer accepts the word this cycle
//   busy                  high while draining
//   drain_done            one-cycle pulse after the final word is accepted
//   overflow              sticky signed-overflow flag, cleared only by reset
//
// state | meaning
// IDLE  | accepting accumulate updates, waiting for store_output
// DRAIN | presenting words to the output buffer, updates dropped

module accumulator_bank #(
    parameter int ARR_SIZE    = 4,
    parameter int VERTICAL_BW = 32,
    parameter int ACC_BW      = 32,
    parameter int DEPTH       = 4,
    parameter int ADDR_W      = 4,
    localparam int ROW_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    input  logic [ROW_W-1:0]                in_row,
    input  logic [ARR_SIZE*VERTICAL_BW-1:0] accumulated_val,
    input  logic                            acc_clear,
    input  logic                            sat_en,
    input  logic                            store_output,
    input  logic [ADDR_W-1:0]               op_buffer_address,
    output logic [ACC_BW-1:0]               output_data,
    output logic [ADDR_W-1:0]               output_buffer_addr,
    output logic                            output_buffer_enable,
    input  logic                            output_buffer_ready,
    output logic                            busy,
    output logic                            drain_done,
    output logic                            overflow
);

    localparam int N_ENT = DEPTH * ARR_SIZE;
    localparam int CNT_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

    localparam logic [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ACC_BW-1:0]     acc_q [N_ENT];
    logic [ACC_BW-1:0]     acc_d [N_ENT];
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic                  en_q, en_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    // Per-entry adder: both operands sign-extended to ACC_BW+1 so overflow
    // shows up as a disagreement between the top two bits of the sum.
    logic [ACC_BW:0]       lane_ext [N_ENT];
    logic [ACC_BW:0]       sum_w    [N_ENT];
    logic                  ovf_w    [N_ENT];
    logic [ACC_BW-1:0]     res_w    [N_ENT];

    for (genvar e = 0; e < N_ENT; e++) begin : g_ent
        localparam int LANE = e % ARR_SIZE;
        logic [VERTICAL_BW-1:0] lane;
        assign lane        = accumulated_val[LANE*VERTICAL_BW +: VERTICAL_BW];
        assign lane_ext[e] = {{(ACC_BW+1-VERTICAL_BW){lane[VERTICAL_BW-1]}}, lane};
        assign sum_w[e]    = {acc_q[e][ACC_BW-1], acc_q[e]} + lane_ext[e];
        assign ovf_w[e]    = sum_w[e][ACC_BW] ^ sum_w[e][ACC_BW-1];
        always_comb begin
            res_w[e] = sum_w[e][ACC_BW-1:0];
            if (ovf_w[e] && sat_en) begin
                res_w[e] = sum_w[e][ACC_BW] ? ACC_MIN : ACC_MAX;
            end
        end
    end

    logic accept;
    logic last_word;

    assign accept    = en_q && output_buffer_ready;
    assign last_word = (idx_q == CNT_W'(N_ENT - 1));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        base_d  = base_q;
        en_d    = en_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int e = 0; e < N_ENT; e++) begin
                        // Rows outside 0..DEPTH-1 never match, so such writes drop.
                        if (in_row == ROW_W'(e / ARR_SIZE)) begin
                            if (acc_clear) begin
                                acc_d[e] = lane_ext[e][ACC_BW-1:0];
                            end else begin
                                acc_d[e] = res_w[e];
                                if (ovf_w[e]) begin
                                    ovf_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                // The update above lands on the same edge the drain starts,
                // so the first drained word already reflects it.
                if (store_output) begin
                    state_d = DRAIN;
                    en_d    = 1'b1;
                    idx_d   = '0;
                    base_d  = op_buffer_address;
                end
            end
            DRAIN: begin
                if (accept) begin
                    acc_d[idx_q] = '0;
                    if (last_word) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int e = 0; e < N_ENT; e++) begin
                acc_q[e] <= '0;
            end
            idx_q  <= '0;
            base_q <= '0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            base_q  <= base_d;
            en_q    <= en_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign output_buffer_enable = en_q;
    assign output_data          = en_q ? acc_q[idx_q] : '0;
    assign output_buffer_addr   = en_q ? (base_q + ADDR_W'(idx_q)) : '0;
    assign busy                 = (state_q == DRAIN);
    assign drain_done           = done_q;
    assign overflow             = ovf_q;

endmodule

// File: tb/tb_accumulator_bank.sv
// tb_accumulator_bank
//   Randomised bench for accumulator_bank with a behavioural reference model
//   (plain longint arithmetic over a 16-entry array) checked every cycle, plus
//   hand-computed literal expectations for the directed scenarios.

module tb_accumulator_bank;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid = 1'b0;
    logic [1:0]   in_row = '0;
    logic [127:0] accumulated_val = '0;
    logic         acc_clear = 1'b0;
    logic         sat_en = 1'b0;
    logic         store_output = 1'b0;
    logic [3:0]   op_buffer_address = '0;
    logic [31:0]  output_data;
    logic [3:0]   output_buffer_addr;
    logic         output_buffer_enable;
    logic         output_buffer_ready = 1'b1;
    logic         busy;
    logic         drain_done;
    logic         overflow;

    accumulator_bank dut (
        .clk                  (clk),
        .rst                  (rst),
        .in_valid             (in_valid),
        .in_row               (in_row),
        .accumulated_val      (accumulated_val),
        .acc_clear            (acc_clear),
        .sat_en               (sat_en),
        .store_output         (store_output),
        .op_buffer_address    (op_buffer_address),
        .output_data          (output_data),
        .output_buffer_addr   (output_buffer_addr),
        .output_buffer_enable (output_buffer_enable),
        .output_buffer_ready  (output_buffer_ready),
        .busy                 (busy),
        .drain_done           (drain_done),
        .overflow             (overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    localparam longint MAXV = 64'sh7FFF_FFFF;
    localparam longint MINV = -64'sh8000_0000;
    localparam longint MOD  = 64'sh1_0000_0000;

    longint   m [16];
    bit       m_busy = 1'b0;
    int       m_k    = 0;
    bit [3:0] m_base = '0;
    bit       m_done = 1'b0;
    bit       m_ovf  = 1'b0;
    longint   s, lane;
    int       e;

    initial for (int i = 0; i < 16; i++) m[i] = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) m[i] = 0;
            m_busy = 0; m_k = 0; m_base = '0; m_done = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (in_valid) begin
                    for (int l = 0; l < 4; l++) begin
                        e    = int'(in_row) * 4 + l;
                        lane = longint'($signed(accumulated_val[l*32 +: 32]));
                        if (acc_clear) begin
                            m[e] = lane;
                        end else begin
                            s = m[e] + lane;
                            if (s > MAXV || s < MINV) m_ovf = 1;
                            if (s > MAXV) s = sat_en ? MAXV : s - MOD;
                            if (s < MINV) s = sat_en ? MINV : s + MOD;
                            m[e] = s;
                        end
                    end
                end
                if (store_output) begin
                    m_busy = 1; m_k = 0; m_base = op_buffer_address;
                end
            end else if (output_buffer_ready) begin
                m[m_k] = 0;
                if (m_k == 15) begin
                    m_busy = 0; m_done = 1;
                end else begin
                    m_k++;
                end
            end
        end
    end

    logic [31:0] exp_data;
    logic [3:0]  exp_addr;

    always @(negedge clk) begin
        if (chk_on) begin
            exp_data = m_busy ? 32'(m[m_k]) : 32'd0;
            exp_addr = m_busy ? 4'(m_base + 4'(m_k)) : 4'd0;
            chk("enable",   output_buffer_enable, m_busy);
            chk("busy",     busy,                 m_busy);
            chk("done",     drain_done,           m_done);
            chk("overflow", overflow,             m_ovf);
            chk("data",     output_data,          exp_data);
            chk("addr",     output_buffer_addr,   exp_addr);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [31:0] got_data [16];
    logic [3:0]  got_addr [16];
    int          cycles, n_acc;

    task automatic do_reset();
        @(posedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic acc(input logic [1:0] row, input logic [127:0] v, input bit clr, input bit sat);
        @(negedge clk);
        in_valid = 1'b1; in_row = row; accumulated_val = v; acc_clear = clr; sat_en = sat;
        @(negedge clk);
        in_valid = 1'b0; acc_clear = 1'b0;
    endtask

    function automatic logic [31:0] rv();
        logic [31:0] r;
        case ($urandom % 3)
            0:       r = $urandom;
            1:       r = 32'h7FFF_FF00 + ($urandom % 512);
            default: r = 32'h8000_0000 + ($urandom % 512);
        endcase
        return r;
    endfunction

    // mode 0: ready always high; 1: ready low on even enabled cycles; 2: random
    task automatic drain(input logic [3:0] base, input int mode, input bit noise, input bit coincide);
        int  en_cnt;
        bit  done;
        en_cnt = 0; done = 0; cycles = 0; n_acc = 0;
        for (int i = 0; i < 16; i++) begin got_data[i] = 'x; got_addr[i] = 'x; end
        @(negedge clk);
        store_output = 1'b1; op_buffer_address = base; output_buffer_ready = 1'b1;
        if (coincide) begin
            in_valid = 1'b1; in_row = 2'($urandom); acc_clear = 1'($urandom);
            accumulated_val = {rv(), rv(), rv(), rv()};
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            store_output = 1'b0; in_valid = 1'b0; acc_clear = 1'b0;
            if (drain_done) begin done = 1; break; end
            if (output_buffer_enable) begin
                case (mode)
                    0:       output_buffer_ready = 1'b1;
                    1:       output_buffer_ready = en_cnt[0];
                    default: output_buffer_ready = 1'($urandom);
                endcase
                en_cnt++; cycles++;
                if (noise) begin
                    in_valid = 1'b1; in_row = 2'($urandom); acc_clear = 1'($urandom);
                    accumulated_val = {$urandom, $urandom, $urandom, $urandom};
                    store_output = 1'b1;
                end
                if (output_buffer_ready && n_acc < 16) begin
                    got_data[n_acc] = output_data;
                    got_addr[n_acc] = output_buffer_addr;
                    n_acc++;
                end
            end
        end
        if (!done) chk("drain_timeout", 1'b0, 1'b1);
        output_buffer_ready = 1'b1;
    endtask

    task automatic check_row0_words(input string tag);
        chk({tag, "_w0"}, got_data[0], 32'd75);
        chk({tag, "_a0"}, got_addr[0], 4'hA);
        chk({tag, "_w1"}, got_data[1], 32'd55);
        chk({tag, "_a1"}, got_addr[1], 4'hB);
        chk({tag, "_w2"}, got_data[2], 32'd35);
        chk({tag, "_w3"}, got_data[3], 32'd15);
        chk({tag, "_a3"}, got_addr[3], 4'hD);
        chk({tag, "_w6"}, got_data[6], 32'd0);
        chk({tag, "_a6"}, got_addr[6], 4'h0);
        chk({tag, "_a15"}, got_addr[15], 4'h9);
        chk({tag, "_count"}, n_acc, 16);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] v;
        int  cnt, t;
        bit  saw_done;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        chk_on = 1'b1;
        #2 rst = 1'b1;

        // reset state and an all-zero drain
        @(negedge clk);
        chk("rst_enable", output_buffer_enable, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_done", drain_done, 1'b0);
        drain(4'h0, 0, 0, 0);
        chk("zero_drain_cycles", cycles, 16);
        chk("zero_drain_count", n_acc, 16);
        chk("zero_drain_w9", got_data[9], 32'd0);

        // row 0: overwrite then add, drain from 0xA with address wrap
        acc(2'd0, {32'd10, 32'd20, 32'd30, 32'd40}, 1'b1, 1'b0);
        acc(2'd0, {32'd5, 32'd15, 32'd25, 32'd35}, 1'b0, 1'b0);
        drain(4'hA, 0, 0, 0);
        check_row0_words("row0");
        chk("row0_cycles", cycles, 16);

        // same tile under alternating backpressure
        acc(2'd0, {32'd10, 32'd20, 32'd30, 32'd40}, 1'b1, 1'b0);
        acc(2'd0, {32'd5, 32'd15, 32'd25, 32'd35}, 1'b0, 1'b0);
        drain(4'hA, 1, 0, 0);
        check_row0_words("bp");
        chk("bp_cycles", cycles, 32);

        // saturation and wrap on row 1 lane 0
        do_reset();
        acc(2'd1, {96'd0, 32'h7FFF_FFF0}, 1'b1, 1'b1);
        acc(2'd1, {96'd0, 32'h0000_0020}, 1'b0, 1'b1);
        chk("sat_overflow", overflow, 1'b1);
        drain(4'h0, 0, 0, 0);
        chk("sat_value", got_data[4], 32'h7FFF_FFFF);
        do_reset();
        acc(2'd1, {96'd0, 32'h7FFF_FFF0}, 1'b1, 1'b0);
        acc(2'd1, {96'd0, 32'h0000_0020}, 1'b0, 1'b0);
        chk("wrap_overflow", overflow, 1'b1);
        drain(4'h0, 0, 0, 0);
        chk("wrap_value", got_data[4], 32'h8000_0010);
        chk("wrap_sticky", overflow, 1'b1);

        // randomised accumulate / drain rounds
        for (int r = 0; r < 6; r++) begin
            repeat (12) begin
                for (int l = 0; l < 4; l++) v[l*32 +: 32] = rv();
                acc(2'($urandom), v, ($urandom % 4) == 0, 1'($urandom));
            end
            drain(4'($urandom), r % 3, 0, r[0]);
            chk("rand_count", n_acc, 16);
        end

        // traffic during a drain is ignored; next drain is empty
        for (int rr = 0; rr < 4; rr++) acc(2'(rr), {32'd1, 32'd2, 32'd3, 32'd4}, 1'b1, 1'b0);
        drain(4'h2, 2, 1, 0);
        chk("noise_w0", got_data[0], 32'd4);
        chk("noise_w15", got_data[15], 32'd1);
        drain(4'h2, 0, 0, 0);
        chk("after_noise_w0", got_data[0], 32'd0);
        chk("after_noise_w15", got_data[15], 32'd0);

        // reset in the middle of a drain
        for (int rr = 0; rr < 4; rr++) acc(2'(rr), {32'd7, 32'd8, 32'd9, 32'd6}, 1'b0, 1'b0);
        @(negedge clk);
        store_output = 1'b1; op_buffer_address = 4'h3; output_buffer_ready = 1'b1;
        @(negedge clk);
        store_output = 1'b0;
        cnt = 0; t = 0;
        while (cnt < 5 && t < 100) begin
            if (output_buffer_enable) cnt++;
            t++;
            if (cnt < 5) @(negedge clk);
        end
        chk("abort_reached5", cnt, 5);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("abort_enable", output_buffer_enable, 1'b0);
        chk("abort_busy", busy, 1'b0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (drain_done) saw_done = 1'b1;
        end
        @(posedge clk); #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (drain_done) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 1'b0);
        drain(4'h3, 0, 0, 0);
        chk("abort_next_w5", got_data[5], 32'd0);
        chk("abort_next_w0", got_data[0], 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "timeout");
    end

endmodule
